// File: rtl/crc_check_byte_en_if.sv
// rtl/crc_check_byte_en_if.sv - beat stream and frame result bundle for crc_check_byte_en
//
// Purpose: carries the receive beat stream into the CRC checker and the
// per-frame result fields back out.
// Ports (signals):
//   din[DWIDTH]      beat data, byte 0 = din[7:0] is first on the wire
//   byteEn[DWIDTH/8] per-byte valid
//   dlast            last beat of frame
//   flitEn           beat valid, accepted on every edge where it is 1
//   crc_ok           frame passed (qualified by crc_out_vld)
//   err_runt         frame shorter than FCS length + 1 bytes
//   err_mask         illegal byteEn seen in frame
//   frame_len[16]    byte count including FCS, saturating
//   crc_out_vld      one-cycle result strobe
//   good_cnt[32]     frames passed, wrapping
//   bad_cnt[32]      frames failed, wrapping
// master modport: stream source / result sink. slave modport: the checker.
interface crc_check_byte_en_if #(
   parameter int DWIDTH = 64
);
   logic [DWIDTH-1:0]   din;
   logic [DWIDTH/8-1:0] byteEn;
   logic                dlast;
   logic                flitEn;
   logic                crc_ok;
   logic                err_runt;
   logic                err_mask;
   logic [15:0]         frame_len;
   logic                crc_out_vld;
   logic [31:0]         good_cnt;
   logic [31:0]         bad_cnt;

   modport master (
      output din, byteEn, dlast, flitEn,
      input  crc_ok, err_runt, err_mask, frame_len, crc_out_vld, good_cnt, bad_cnt
   );

   modport slave (
      input  din, byteEn, dlast, flitEn,
      output crc_ok, err_runt, err_mask, frame_len, crc_out_vld, good_cnt, bad_cnt
   );
endinterface

// File: rtl/crc_check_byte_en.sv
// rtl/crc_check_byte_en.sv - streaming CRC checker with per-byte enables
//
// Purpose: runs the CRC over each frame's data plus trailing FCS and compares
// the output-domain result against the polynomial residue. Three stages:
// input register, CRC/count/error accumulation, output register.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  crc_check_byte_en_if.slave (beat stream in, frame results out)
module crc_check_byte_en #(
   parameter int                   DWIDTH    = 64,
   parameter int                   CRC_WIDTH = 32,
   parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 32'h04C11DB7,
   parameter logic [CRC_WIDTH-1:0] INIT      = 32'hFFFFFFFF,
   parameter logic [CRC_WIDTH-1:0] XOR_OUT   = 32'hFFFFFFFF,
   parameter bit                   REFIN     = 1'b1,
   parameter bit                   REFOUT    = 1'b1,
   parameter logic [CRC_WIDTH-1:0] RESIDUE   = 32'h2144DF1C
) (
   input logic                 clk,
   input logic                 rst,
   crc_check_byte_en_if.slave  bus
);

   localparam int NB = DWIDTH / 8;
   localparam int CB = CRC_WIDTH / 8;
   localparam logic [NB-1:0] BE_ONE   = 1;
   localparam logic [15:0]   MIN_LEN  = 16'(CB + 1);

   typedef enum logic {IDLE, IN_FRAME} state_t;

   // One byte through a normal-form MSB-first CRC register; REFIN feeds
   // the byte LSB-first by reversing it before the shift loop.
   function automatic logic [CRC_WIDTH-1:0] crc_byte(input logic [CRC_WIDTH-1:0] c_in,
                                                    input logic [7:0] d);
      logic [CRC_WIDTH-1:0] c;
      logic [7:0]           b;
      logic                 fb;
      c = c_in;
      for (int k = 0; k < 8; k++) b[k] = REFIN ? d[7-k] : d[k];
      for (int k = 7; k >= 0; k--) begin
         fb = c[CRC_WIDTH-1] ^ b[k];
         c  = {c[CRC_WIDTH-2:0], 1'b0};
         if (fb) c = c ^ CRC_POLY;
      end
      return c;
   endfunction

   function automatic logic [CRC_WIDTH-1:0] bitrev(input logic [CRC_WIDTH-1:0] v);
      logic [CRC_WIDTH-1:0] r;
      for (int k = 0; k < CRC_WIDTH; k++) r[k] = v[CRC_WIDTH-1-k];
      return r;
   endfunction

   // Stage 1: input register; disabled bytes are zeroed so no stale data
   // can leak forward.
   logic [DWIDTH-1:0] s1_din;
   logic [NB-1:0]     s1_be;
   logic              s1_last;
   logic              s1_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s1_din  <= '0;
         s1_be   <= '0;
         s1_last <= 1'b0;
      end else begin
         s1_vld  <= bus.flitEn;
         s1_be   <= bus.byteEn;
         s1_last <= bus.dlast;
         for (int i = 0; i < NB; i++)
            s1_din[8*i +: 8] <= bus.byteEn[i] ? bus.din[8*i +: 8] : 8'h00;
      end
   end

   // Stage 2: per-frame accumulation
   state_t               state;
   logic [CRC_WIDTH-1:0] crc_reg;
   logic [15:0]          byte_cnt;
   logic                 err_mask_acc;

   logic                 s2_done;
   logic [CRC_WIDTH-1:0] s2_crc;
   logic [15:0]          s2_len;
   logic                 s2_merr;

   logic [CRC_WIDTH-1:0] crc_nxt;
   logic [15:0]          cnt_nxt;
   logic                 merr_nxt;
   logic [15:0]          beat_cnt;
   logic [16:0]          cnt_sum;
   logic                 mask_ok;

   always_comb begin
      // IDLE means the previous beat closed a frame, so this beat starts fresh.
      crc_nxt  = (state == IDLE) ? INIT : crc_reg;
      beat_cnt = '0;
      for (int i = 0; i < NB; i++) begin
         if (s1_be[i]) begin
            crc_nxt  = crc_byte(crc_nxt, s1_din[8*i +: 8]);
            beat_cnt = beat_cnt + 16'd1;
         end
      end
      cnt_sum = {1'b0, (state == IDLE) ? 16'd0 : byte_cnt} + {1'b0, beat_cnt};
      cnt_nxt = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      // Last beat: non-zero and contiguous from byte 0, i.e. 2^n-1.
      if (s1_last)
         mask_ok = (s1_be != '0) && ((s1_be & (s1_be + BE_ONE)) == '0);
      else
         mask_ok = &s1_be;
      merr_nxt = ((state == IDLE) ? 1'b0 : err_mask_acc) | ~mask_ok;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         crc_reg      <= INIT;
         byte_cnt     <= '0;
         err_mask_acc <= 1'b0;
         s2_done      <= 1'b0;
         s2_crc       <= '0;
         s2_len       <= '0;
         s2_merr      <= 1'b0;
      end else begin
         s2_done <= s1_vld & s1_last;
         if (s1_vld) begin
            if (s1_last) begin
               state        <= IDLE;
               crc_reg      <= INIT;
               byte_cnt     <= '0;
               err_mask_acc <= 1'b0;
               s2_crc       <= crc_nxt;
               s2_len       <= cnt_nxt;
               s2_merr      <= merr_nxt;
            end else begin
               state        <= IN_FRAME;
               crc_reg      <= crc_nxt;
               byte_cnt     <= cnt_nxt;
               err_mask_acc <= merr_nxt;
            end
         end
      end
   end

   // Stage 3: result evaluation and output registers
   logic [CRC_WIDTH-1:0] res;
   logic                 runt;
   logic                 ok;

   assign res  = (REFOUT ? bitrev(s2_crc) : s2_crc) ^ XOR_OUT;
   assign runt = (s2_len < MIN_LEN);
   assign ok   = (res == RESIDUE) & ~runt & ~s2_merr;

   logic        o_vld;
   logic        o_ok;
   logic        o_runt;
   logic        o_mask;
   logic [15:0] o_len;
   logic [31:0] o_good;
   logic [31:0] o_bad;

   always_ff @(posedge clk) begin
      if (rst) begin
         o_vld  <= 1'b0;
         o_ok   <= 1'b0;
         o_runt <= 1'b0;
         o_mask <= 1'b0;
         o_len  <= '0;
         o_good <= '0;
         o_bad  <= '0;
      end else begin
         o_vld <= s2_done;
         if (s2_done) begin
            o_ok   <= ok;
            o_runt <= runt;
            o_mask <= s2_merr;
            o_len  <= s2_len;
            if (ok) o_good <= o_good + 32'd1;
            else    o_bad  <= o_bad + 32'd1;
         end
      end
   end

   assign bus.crc_out_vld = o_vld;
   assign bus.crc_ok      = o_ok;
   assign bus.err_runt    = o_runt;
   assign bus.err_mask    = o_mask;
   assign bus.frame_len   = o_len;
   assign bus.good_cnt    = o_good;
   assign bus.bad_cnt     = o_bad;

endmodule

// File: tb/tb_crc_check_byte_en.sv
// tb/tb_crc_check_byte_en.sv - self-checking bench for crc_check_byte_en
module tb_crc_check_byte_en;

   logic clk;
   logic rst;
   bit   chk_en;
   int   cyc;
   int   strobes;
   int   checks;
   int   errors;

   crc_check_byte_en_if #(.DWIDTH(64)) bus ();

   crc_check_byte_en dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [63:0] GOOD0 = 64'h3837363534333231;   // "12345678"
   localparam logic [63:0] GOOD1 = 64'h000000CBF4392639;   // "9" + FCS 26 39 F4 CB
   localparam logic [63:0] FLIP0 = 64'h3837363535333231;   // byte 3 bit 0 inverted

   typedef struct {
      int          due;
      bit          ok;
      bit          runt;
      bit          mask;
      logic [15:0] len;
   } exp_t;

   exp_t       expq[$];
   logic [7:0] fbytes[$];
   bit         fmask;
   exp_t       held;
   logic [31:0] g_exp;
   logic [31:0] b_exp;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reflected right-shift CRC-32 with final XOR: the output-domain value
   // the checker must compare against its residue.
   function automatic logic [31:0] ref_crc(input logic [7:0] b[$]);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < b.size(); i++) begin
         c = c ^ {24'h0, b[i]};
         for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c ^ 32'hFFFFFFFF;
   endfunction

   // Model: capture accepted beats at the edge, compare outputs mid-cycle.
   always begin : model_chk
      exp_t e;
      bit   legal;
      @(posedge clk);
      cyc++;
      if (rst) begin
         expq.delete();
         fbytes.delete();
         fmask = 1'b0;
         held  = '{0, 1'b0, 1'b0, 1'b0, 16'h0};
         g_exp = 0;
         b_exp = 0;
      end else if (bus.flitEn) begin
         legal = bus.dlast ? (bus.byteEn inside {8'h01, 8'h03, 8'h07, 8'h0F,
                                                 8'h1F, 8'h3F, 8'h7F, 8'hFF})
                           : (bus.byteEn == 8'hFF);
         if (!legal) fmask = 1'b1;
         for (int k = 0; k < 8; k++)
            if (bus.byteEn[k]) fbytes.push_back(bus.din[8*k +: 8]);
         if (bus.dlast) begin
            e.due  = cyc + 2;
            e.len  = (fbytes.size() > 65535) ? 16'hFFFF : 16'(fbytes.size());
            e.runt = (fbytes.size() < 5);
            e.mask = fmask;
            e.ok   = (ref_crc(fbytes) == 32'h2144DF1C) && !e.runt && !e.mask;
            expq.push_back(e);
            fbytes.delete();
            fmask = 1'b0;
         end
      end
      @(negedge clk);
      if (chk_en) begin
         if (expq.size() > 0 && expq[0].due == cyc) begin
            check("crc_out_vld", {31'h0, bus.crc_out_vld}, 32'h1);
            held = expq.pop_front();
            if (held.ok) g_exp = g_exp + 1;
            else         b_exp = b_exp + 1;
         end else begin
            check("crc_out_vld", {31'h0, bus.crc_out_vld}, 32'h0);
         end
         if (bus.crc_out_vld) strobes++;
         check("crc_ok",    {31'h0, bus.crc_ok},   {31'h0, held.ok});
         check("err_runt",  {31'h0, bus.err_runt}, {31'h0, held.runt});
         check("err_mask",  {31'h0, bus.err_mask}, {31'h0, held.mask});
         check("frame_len", {16'h0, bus.frame_len}, {16'h0, held.len});
         check("good_cnt",  bus.good_cnt, g_exp);
         check("bad_cnt",   bus.bad_cnt,  b_exp);
      end
   end

   task automatic beat(input logic [63:0] d, input logic [7:0] be, input bit last);
      bus.din    = d;
      bus.byteEn = be;
      bus.dlast  = last;
      bus.flitEn = 1'b1;
      @(negedge clk);
      bus.flitEn = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      bus.flitEn = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic good_frame();
      beat(GOOD0, 8'hFF, 1'b0);
      beat(GOOD1, 8'h1F, 1'b1);
   endtask

   initial begin : main
      logic [7:0] q[$];
      int         s0;
      checks     = 0;
      errors     = 0;
      cyc        = 0;
      strobes    = 0;
      chk_en     = 1'b0;
      rst        = 1'b1;
      bus.din    = '0;
      bus.byteEn = '0;
      bus.dlast  = 1'b0;
      bus.flitEn = 1'b0;

      // Pin the model against known CRC-32 values.
      q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      check("model_check_value", ref_crc(q), 32'hCBF43926);
      q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
      check("model_residue", ref_crc(q), 32'h2144DF1C);

      idle(2);
      rst = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      check("reset_vld", {31'h0, bus.crc_out_vld}, 32'h0);
      check("reset_good", bus.good_cnt, 32'h0);
      check("reset_len", {16'h0, bus.frame_len}, 32'h0);

      // Good frame
      good_frame();
      idle(4);
      check("good_ok", {31'h0, bus.crc_ok}, 32'h1);
      check("good_len", {16'h0, bus.frame_len}, 32'd13);
      check("good_cnt1", bus.good_cnt, 32'd1);

      // Bit flip
      beat(FLIP0, 8'hFF, 1'b0);
      beat(GOOD1, 8'h1F, 1'b1);
      idle(4);
      check("flip_ok", {31'h0, bus.crc_ok}, 32'h0);
      check("flip_runt", {31'h0, bus.err_runt}, 32'h0);
      check("flip_mask", {31'h0, bus.err_mask}, 32'h0);
      check("flip_bad", bus.bad_cnt, 32'd1);

      // Runt
      beat(64'h0000000000030201, 8'h07, 1'b1);
      idle(4);
      check("runt_flag", {31'h0, bus.err_runt}, 32'h1);
      check("runt_ok", {31'h0, bus.crc_ok}, 32'h0);
      check("runt_len", {16'h0, bus.frame_len}, 32'd3);

      // Mask error on a non-last beat
      beat(GOOD0, 8'h7F, 1'b0);
      beat(GOOD1, 8'h1F, 1'b1);
      idle(4);
      check("mask_nl", {31'h0, bus.err_mask}, 32'h1);
      check("mask_nl_ok", {31'h0, bus.crc_ok}, 32'h0);
      check("mask_nl_len", {16'h0, bus.frame_len}, 32'd12);

      // Non-contiguous last mask
      beat(GOOD0, 8'hFF, 1'b0);
      beat(GOOD1, 8'h0B, 1'b1);
      idle(4);
      check("mask_0b", {31'h0, bus.err_mask}, 32'h1);

      // Empty last mask
      beat(GOOD1, 8'h00, 1'b1);
      idle(4);
      check("mask_00", {31'h0, bus.err_mask}, 32'h1);
      check("mask_00_len", {16'h0, bus.frame_len}, 32'd0);

      // Consecutive single-beat frames
      s0 = strobes;
      beat(GOOD0, 8'hFF, 1'b1);
      beat(GOOD1, 8'hFF, 1'b1);
      idle(4);
      check("single_strobes", strobes - s0, 2);
      check("single_len", {16'h0, bus.frame_len}, 32'd8);
      check("single_bad", bus.bad_cnt, 32'd7);

      // Back-to-back, then with random gaps
      do_reset();
      s0 = strobes;
      repeat (3) good_frame();
      repeat (3) begin
         beat(GOOD0, 8'hFF, 1'b0);
         idle($urandom_range(0, 2));
         beat(GOOD1, 8'h1F, 1'b1);
         idle($urandom_range(0, 2));
      end
      idle(4);
      check("b2b_strobes", strobes - s0, 6);
      check("b2b_good", bus.good_cnt, 32'd6);
      check("b2b_bad", bus.bad_cnt, 32'd0);

      // Reset mid-frame
      beat(GOOD0, 8'hFF, 1'b0);
      do_reset();
      s0 = strobes;
      good_frame();
      idle(4);
      check("rst_strobes", strobes - s0, 1);
      check("rst_good", bus.good_cnt, 32'd1);
      check("rst_bad", bus.bad_cnt, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/crc_check_byte_en.md
# crc_check_byte_en

Streaming CRC checker with per-byte enables: the receive-side counterpart of the byte-enable CRC generator. Consumes a frame whose final CRC_WIDTH/8 bytes are the FCS and runs the CRC over data plus FCS. Compares the result against the polynomial's fixed residue and reports pass/fail per frame with a frame length. Sits after the link RX datapath, before the frame is released to the user side; no backpressure.

## Interface
- DWIDTH, 64: beat width in bits; multiple of 8, > 8.
- CRC_WIDTH, 32: CRC width in bits; multiple of 8.
- CRC_POLY, 32'h04C11DB7: generator polynomial, normal form.
- INIT, 32'hFFFFFFFF: CRC register value at frame start.
- XOR_OUT, 32'hFFFFFFFF: final XOR.
- REFIN, 1: bytes processed LSB-first when 1.
- REFOUT, 1: result bit-reversed before XOR_OUT when 1.
- RESIDUE, 32'h2144DF1C: expected output-domain value over data+FCS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- din  in  DWIDTH  beat data; byte i = din[8i+7:8i]; byte 0 is first on the wire.
- byteEn  in  DWIDTH/8  per-byte valid.
- dlast  in  1  last beat of frame.
- flitEn  in  1  beat valid; a beat is accepted on every edge where it is 1.
- crc_ok  out  1  frame passed (qualified by crc_out_vld).
- err_runt  out  1  frame shorter than CRC_WIDTH/8+1 bytes.
- err_mask  out  1  illegal byteEn seen in frame.
- frame_len  out  16  byte count including FCS, saturating at 16'hFFFF.
- crc_out_vld  out  1  one-cycle result strobe.
- good_cnt  out  32  frames with crc_ok=1, wrapping.
- bad_cnt  out  32  frames with crc_ok=0, wrapping.

## Operation
- **Legal byteEn:** on non-last beats it must be all ones. On the last beat it must be 2^n−1 with 1 ≤ n ≤ DWIDTH/8 (contiguous from byte 0). Any other value sets a sticky per-frame mask error.
- **CRC update:** the per-frame CRC register starts at INIT. Per accepted beat it advances over enabled bytes in ascending byte order. Disabled bytes do not alter it: no zero-padding, no revert stage. For an illegal mask, only the enabled bytes are processed.
- **Result:** res = (REFOUT ? bitrev(reg) : reg) ^ XOR_OUT. crc_ok = (res == RESIDUE) & ~err_runt & ~err_mask.
- **Length:** frame_len sums popcount(byteEn) over accepted beats.
- **Counters:** at each crc_out_vld, good_cnt increments if crc_ok=1, otherwise bad_cnt increments. Both wrap modulo 2^32.
- **Frame boundary:** after a dlast beat, the CRC register returns to INIT, the byte count to 0, and the sticky errors to 0 for the next beat.
- **State machine:** IDLE → IN_FRAME on a non-last beat. IN_FRAME → IDLE on a dlast beat. A dlast beat in IDLE is a single-beat frame. flitEn=0 in either state holds all state.
- **Reset:** crc_out_vld, crc_ok, err_runt, err_mask, frame_len, good_cnt and bad_cnt all go to 0. The CRC register goes to INIT and the state to IDLE. A partial frame is discarded with no result strobe; beats in flight in the pipeline are dropped.

## Timing
- Stage 1 registers din & mask, byteEn, dlast and flitEn. Stage 2 updates the CRC register, byte count and error flags. Stage 3 registers the outputs.
- Latency: the dlast beat is sampled at edge T; crc_out_vld = 1 for exactly one cycle after edge T+2, with all result fields valid during that cycle.
- crc_ok, err_runt, err_mask and frame_len hold their last values until the next strobe.
- Back-to-back frames: a new frame may start on the beat immediately after dlast. Consecutive single-beat frames on consecutive cycles produce strobes on consecutive cycles.
- Throughput: one beat per clock, with no bubble required.

## Test plan
- **Good CRC-32 frame** (defaults). Beat0 = "12345678", byteEn=8'hFF. Beat1 = "9",26,39,F4,CB, byteEn=8'h1F, dlast. Expected: strobe 2 edges after beat1, crc_ok=1, frame_len=13, good_cnt=1.
- **Bit flip:** same frame with bit 0 of byte 3 inverted. Expected: crc_ok=0, err_runt=0, err_mask=0, bad_cnt=1.
- **Runt:** single beat, byteEn=8'h07, dlast. Expected: err_runt=1, crc_ok=0, frame_len=3.
- **Mask errors:**
  - Non-last beat with byteEn=8'h7F → err_mask=1, crc_ok=0.
  - Separate frame whose last beat has byteEn=8'h0B → err_mask=1.
  - Last beat with byteEn=8'h00 → err_mask=1.
- **Back-to-back with gaps:** the good frame repeated 3× with no idle cycles, then again with random flitEn=0 gaps inserted. Expected: every strobe reports crc_ok=1 and frame_len=13; strobe count is 6; good_cnt=6.
- **Reset mid-frame:** assert rst after beat0 of the good frame, then send a complete good frame. Expected: no strobe for the aborted frame; good_cnt=1 and bad_cnt=0 afterward.
